sd_spi_responder: RTL and testbench
===================================

# sd_spi_responder

SPI-mode SD card responder: the card-side end of the SD SPI protocol, backed by a synchronous byte-wide sector memory. It decodes host commands (init, read-block, write-block), returns R1/R3/R7 responses and data tokens, and streams 512-byte sectors to or from memory. It gives the SD host controller and sector cache a deterministic card for bench and loopback builds. All logic runs on the system clock; `sclk`, `cs` and `mosi` are oversampled.

## Interface
- `ADDR_BITS`, 16: sector-number width; memory holds 2^ADDR_BITS sectors of 512 B.
- `BUSY_BYTES`, 4: number of 0x00 busy bytes sent after a write data response.
- `clk` in 1: system clock, 25 MHz; host `sclk` ≤ clk/4.
- `reset` in 1: asynchronous, active-high.
- `cs` in 1: chip select from host, active-low.
- `sclk` in 1: SPI clock from host, mode 0.
- `mosi` in 1: host-to-card data, MSB first.
- `miso` out 1: card-to-host data; 1 when not driving.
- `mem_addr` out ADDR_BITS+9: {sector, byte index}.
- `mem_rdata` in 8: read data, valid 1 clk after `mem_addr`.
- `mem_wdata` out 8: write data.
- `mem_wr` out 1: one-clk write strobe.
- `idle_state` out 1: card in idle (pre-ACMD41) state.
- `active` out 1: FSM outside CMD_WAIT.

## Operation
- `cs`, `sclk` and `mosi` pass through 2-flop synchronizers. Detect `sclk` rise and fall from the synchronized value. Sample `mosi` on rise. Update `miso` on fall.
- Byte framing: 3-bit counter counts rises while `cs`=0. Each 8th rise completes an rx byte. The tx byte loads at the next fall, with bit 7 driven immediately.
- `cs`=1 at any time: go to CMD_WAIT, clear the bit counter, `miso`=1. Bytes already written stay written. `idle_state` is kept.
- CMD_WAIT: rx byte with bits[7:6]=01 starts a command. Go to CMD_RX and collect 5 more bytes (32-bit arg, CRC ignored).
- NCR: send one 0xFF byte, then the response.
- Responses; R1 bit0 = `idle_state`:
  - CMD0: 0x01, sets `idle_state`.
  - CMD8: 0x01 00 00 01 arg[7:0].
  - CMD55, CMD16: R1.
  - ACMD41 (CMD41 right after CMD55): clears `idle_state`, then R1 = 0x00.
  - CMD58: R1 + OCR 0x00FF8000.
  - Other commands: R1 | 0x04.
- Addressing is byte-based. Sector = arg[ADDR_BITS+8:9].
  - arg[31:ADDR_BITS+9] ≠ 0 on CMD17/24: R1 | 0x20, no data phase.
  - CMD17/24 while `idle_state`=1: 0x05, no data phase.
- CMD17 read: R1 0x00 → RD_GAP (one 0xFF) → RD_TOKEN 0xFE → RD_DATA 512 bytes from `mem_addr` = {sector, 0..511} → RD_CRC 0xFF, 0xFF → CMD_WAIT.
  - Issue `mem_addr` at least 2 clk before the tx byte load that uses it.
- CMD24 write: R1 0x00 → WR_TOKEN: discard 0xFF bytes until 0xFE. Any other byte → CMD_WAIT with no write.
  - WR_DATA: each rx byte gives one `mem_wr` pulse at {sector, index}, index 0..511.
  - WR_CRC: 2 bytes, ignored.
  - WR_RESP: send 0x05.
  - WR_BUSY: send BUSY_BYTES × 0x00, then CMD_WAIT (`miso`=1).
- Command bytes received during a response or data phase are ignored. Host must wait for completion.

## Timing
- Reset values:
  - `miso`=1, `mem_wr`=0, `mem_addr`=0, `mem_wdata`=0.
  - `idle_state`=1, `active`=0, FSM=CMD_WAIT, ACMD flag=0.
- Input latency: 2 clk synchronizer + 1 clk edge detect. Rx byte is valid 3 clk after the 8th `sclk` rise.
- `miso` changes at most 3 clk after a `sclk` fall. It is stable well before the next rise because `sclk` ≤ clk/4.
- `mem_wr` asserts 1 clk after rx byte completion, one pulse per byte, `mem_addr`/`mem_wdata` valid in the same clk.
- Index counter is 9 bits. The 512th byte ends the data phase; the counter does not wrap into the next sector.
- ACMD flag is set by CMD55 and cleared by any following command.
- Reset mid-transfer: immediate return to the reset values. `mem_wr` deasserts asynchronously.

## Test plan
- Init: CMD0 → 0xFF,0x01. CMD8 arg 0x1AA → 0x01 00 00 01 AA. CMD55 → 0x01. CMD41 → 0x00, `idle_state`=0. CMD58 → 0x00 00 FF 80 00.
- Read: memory sector 3 = byte i at index i. CMD17 arg 0x600 → 0xFF, 0x00, 0xFF, 0xFE, bytes 0x00..0xFF twice, 0xFF 0xFF.
- Write: CMD24 arg 0x400, then 0xFF, 0xFE, 512 bytes 0xA5^i, CRC → 512 `mem_wr` pulses at 0x400..0x5FF, response 0x05, 4×0x00, then 0xFF.
- Pre-init access: after reset, CMD17 → R1 0x05, no data token. CMD99-style opcode CMD5 → 0x05.
- Range: ADDR_BITS=16, CMD17 arg 0x0200_0000 → R1 0x20. Next command is accepted normally.
- Abort: raise `cs` after 100 data bytes of a CMD24 → exactly 100 `mem_wr` pulses, `active`=0 within 3 clk, next CMD17 succeeds.

Source files
------------

// File: rtl/sd_spi_responder_if.sv
// SPI pins and sector-memory port of the SD SPI responder.
// master = host/memory side, slave = card side.
interface sd_spi_responder_if #(
  parameter int ADDR_BITS = 16
);
  logic                 cs;
  logic                 sclk;
  logic                 mosi;
  logic                 miso;
  logic [ADDR_BITS+8:0] mem_addr;
  logic [7:0]           mem_rdata;
  logic [7:0]           mem_wdata;
  logic                 mem_wr;

  modport master (
    output cs, sclk, mosi, mem_rdata,
    input  miso, mem_addr, mem_wdata, mem_wr
  );

  modport slave (
    input  cs, sclk, mosi, mem_rdata,
    output miso, mem_addr, mem_wdata, mem_wr
  );
endinterface

// File: rtl/sd_spi_responder.sv
// Card side of the SD SPI protocol: oversampled SPI slave, command decoder and
// 512-byte sector streaming to/from a synchronous byte-wide memory.
module sd_spi_responder #(
  parameter int ADDR_BITS  = 16,
  parameter int BUSY_BYTES = 4
) (
  input  logic              clk,
  input  logic              reset,
  sd_spi_responder_if.slave bus,
  output logic              idle_state,
  output logic              active
);

  typedef enum logic [3:0] {
    CMD_WAIT, CMD_RX, RESP, RD_GAP, RD_TOKEN, RD_DATA, RD_CRC,
    WR_TOKEN, WR_DATA, WR_CRC, WR_RESP, WR_BUSY
  } state_t;

  localparam logic [8:0] BUSY_N = 9'(BUSY_BYTES);

  logic [1:0]           csSync_q, sclkSync_q, mosiSync_q;
  logic                 sclkPrev_q;
  logic [2:0]           bitCnt_q;
  logic [6:0]           rxShift_q, txShift_q;
  logic [7:0]           txNext_q;
  logic                 miso_q;
  state_t               state_q, after_q;
  logic [8:0]           cnt_q;
  logic [5:0]           cmd_q;
  logic [31:0]          arg_q;
  logic [39:0]          respBuf_q;
  logic [2:0]           respLen_q;
  logic [ADDR_BITS-1:0] sector_q;
  logic [ADDR_BITS+8:0] memAddr_q;
  logic [7:0]           memWdata_q;
  logic                 memWr_q;
  logic                 idle_q, acmd_q;

  logic        csHigh, rise, fall, rxDone;
  logic [7:0]  rxByte, r1;
  logic [31:0] argHigh;
  logic        decIdle, decAcmd;
  logic [39:0] decResp;
  logic [2:0]  decLen;
  state_t      decNext;

  assign csHigh  = csSync_q[1];
  assign rise    = sclkSync_q[1] & ~sclkPrev_q;
  assign fall    = ~sclkSync_q[1] & sclkPrev_q;
  assign rxDone  = ~csHigh & rise & (bitCnt_q == 3'd7);
  assign rxByte  = {rxShift_q, mosiSync_q[1]};
  assign r1      = {7'b0, idle_q};
  assign argHigh = arg_q >> (ADDR_BITS + 9);

  assign bus.miso      = miso_q;
  assign bus.mem_addr  = memAddr_q;
  assign bus.mem_wdata = memWdata_q;
  assign bus.mem_wr    = memWr_q;
  assign idle_state    = idle_q;
  assign active        = (state_q != CMD_WAIT);

  // Response bytes are queued MSB-first in decResp; decLen says how many to send.
  always_comb begin
    decIdle = idle_q;
    decAcmd = 1'b0;
    decResp = {r1 | 8'h04, 32'h0};
    decLen  = 3'd1;
    decNext = CMD_WAIT;
    case (cmd_q)
      6'd0: begin
        decIdle = 1'b1;
        decResp = {8'h01, 32'h0};
      end
      6'd8: begin
        decResp = {r1, 24'h000001, arg_q[7:0]};
        decLen  = 3'd5;
      end
      6'd16: decResp = {r1, 32'h0};
      6'd55: begin
        decAcmd = 1'b1;
        decResp = {r1, 32'h0};
      end
      6'd41: begin
        if (acmd_q) begin
          decIdle = 1'b0;
          decResp = 40'h0;
        end
      end
      6'd58: begin
        decResp = {r1, 32'h00FF8000};
        decLen  = 3'd5;
      end
      6'd17, 6'd24: begin
        if (argHigh != 32'h0) begin
          decResp = {r1 | 8'h20, 32'h0};
        end else if (!idle_q) begin
          decResp = 40'h0;
          decNext = (cmd_q == 6'd17) ? RD_GAP : WR_TOKEN;
        end
      end
      default: ;
    endcase
  end

  // Every completed rx byte advances the FSM and picks the tx byte for the next slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      csSync_q   <= 2'b11;
      sclkSync_q <= 2'b00;
      mosiSync_q <= 2'b11;
      sclkPrev_q <= 1'b0;
      bitCnt_q   <= 3'd0;
      rxShift_q  <= 7'h0;
      txShift_q  <= 7'h7F;
      txNext_q   <= 8'hFF;
      miso_q     <= 1'b1;
      state_q    <= CMD_WAIT;
      after_q    <= CMD_WAIT;
      cnt_q      <= 9'd0;
      cmd_q      <= 6'd0;
      arg_q      <= 32'h0;
      respBuf_q  <= 40'h0;
      respLen_q  <= 3'd0;
      sector_q   <= '0;
      memAddr_q  <= '0;
      memWdata_q <= 8'h0;
      memWr_q    <= 1'b0;
      idle_q     <= 1'b1;
      acmd_q     <= 1'b0;
    end else begin
      csSync_q   <= {csSync_q[0], bus.cs};
      sclkSync_q <= {sclkSync_q[0], bus.sclk};
      mosiSync_q <= {mosiSync_q[0], bus.mosi};
      sclkPrev_q <= sclkSync_q[1];
      memWr_q    <= 1'b0;
      if (csHigh) begin
        state_q   <= CMD_WAIT;
        bitCnt_q  <= 3'd0;
        miso_q    <= 1'b1;
        txShift_q <= 7'h7F;
        txNext_q  <= 8'hFF;
      end else begin
        if (rise) begin
          rxShift_q <= rxByte[6:0];
          bitCnt_q  <= bitCnt_q + 3'd1;
        end
        if (fall) begin
          if (bitCnt_q == 3'd0) begin
            miso_q    <= txNext_q[7];
            txShift_q <= txNext_q[6:0];
          end else begin
            miso_q    <= txShift_q[6];
            txShift_q <= {txShift_q[5:0], 1'b1};
          end
        end
        if (rxDone) begin
          txNext_q <= 8'hFF;
          case (state_q)
            CMD_WAIT: begin
              if (rxByte[7:6] == 2'b01) begin
                cmd_q   <= rxByte[5:0];
                cnt_q   <= 9'd0;
                state_q <= CMD_RX;
              end
            end
            CMD_RX: begin
              if (cnt_q != 9'd4) begin
                arg_q <= {arg_q[23:0], rxByte};
                cnt_q <= cnt_q + 9'd1;
              end else begin
                idle_q    <= decIdle;
                acmd_q    <= decAcmd;
                respBuf_q <= decResp;
                respLen_q <= decLen;
                after_q   <= decNext;
                sector_q  <= arg_q[ADDR_BITS+8:9];
                memAddr_q <= {arg_q[ADDR_BITS+8:9], 9'd0};
                cnt_q     <= 9'd0;
                state_q   <= RESP;
              end
            end
            RESP: begin
              txNext_q  <= respBuf_q[39:32];
              respBuf_q <= {respBuf_q[31:0], 8'h0};
              if (cnt_q == {6'd0, respLen_q - 3'd1}) begin
                cnt_q   <= 9'd0;
                state_q <= after_q;
              end else begin
                cnt_q <= cnt_q + 9'd1;
              end
            end
            RD_GAP: state_q <= RD_TOKEN;
            RD_TOKEN: begin
              txNext_q <= 8'hFE;
              cnt_q    <= 9'd0;
              state_q  <= RD_DATA;
            end
            RD_DATA: begin
              txNext_q <= bus.mem_rdata;
              if (cnt_q == 9'd511) begin
                cnt_q   <= 9'd0;
                state_q <= RD_CRC;
              end else begin
                cnt_q     <= cnt_q + 9'd1;
                memAddr_q <= {sector_q, cnt_q + 9'd1};
              end
            end
            RD_CRC: begin
              if (cnt_q == 9'd1) state_q <= CMD_WAIT;
              else cnt_q <= cnt_q + 9'd1;
            end
            WR_TOKEN: begin
              if (rxByte == 8'hFE) begin
                cnt_q   <= 9'd0;
                state_q <= WR_DATA;
              end else if (rxByte != 8'hFF) begin
                state_q <= CMD_WAIT;
              end
            end
            WR_DATA: begin
              memWr_q    <= 1'b1;
              memAddr_q  <= {sector_q, cnt_q};
              memWdata_q <= rxByte;
              if (cnt_q == 9'd511) begin
                cnt_q   <= 9'd0;
                state_q <= WR_CRC;
              end else begin
                cnt_q <= cnt_q + 9'd1;
              end
            end
            WR_CRC: begin
              if (cnt_q == 9'd1) begin
                txNext_q <= 8'h05;
                state_q  <= WR_RESP;
              end else begin
                cnt_q <= cnt_q + 9'd1;
              end
            end
            WR_RESP: begin
              if (BUSY_N == 9'd0) begin
                state_q <= CMD_WAIT;
              end else begin
                txNext_q <= 8'h00;
                cnt_q    <= 9'd1;
                state_q  <= WR_BUSY;
              end
            end
            WR_BUSY: begin
              if (cnt_q >= BUSY_N) begin
                state_q <= CMD_WAIT;
              end else begin
                txNext_q <= 8'h00;
                cnt_q    <= cnt_q + 9'd1;
              end
            end
            default: state_q <= CMD_WAIT;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_sd_spi_responder.sv
// Directed bench for sd_spi_responder: bit-level SPI host plus a small sector
// memory whose unwritten bytes read back as the low byte of their address.
module tb_sd_spi_responder;
  localparam int ADDR_BITS  = 16;
  localparam int BUSY_BYTES = 4;

  logic clk = 1'b0;
  logic reset;
  logic idle_state, active;
  int   errors = 0;
  int   checks = 0;

  logic [7:0]  mem [0:4095];
  bit          written [0:4095];
  int          wrCount = 0;
  int          wrAddrErrs = 0;
  int          wrStart = 0;
  logic [24:0] wrBase = 25'h0;

  sd_spi_responder_if #(.ADDR_BITS(ADDR_BITS)) bus ();

  sd_spi_responder #(.ADDR_BITS(ADDR_BITS), .BUSY_BYTES(BUSY_BYTES)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .idle_state(idle_state),
    .active    (active)
  );

  always #20 clk = ~clk;

  // Memory model: one-cycle read latency, write addresses checked for a linear run from wrBase.
  always @(posedge clk) begin
    bus.mem_rdata <= written[bus.mem_addr[11:0]] ? mem[bus.mem_addr[11:0]] : bus.mem_addr[7:0];
    if (bus.mem_wr === 1'b1) begin
      mem[bus.mem_addr[11:0]]     <= bus.mem_wdata;
      written[bus.mem_addr[11:0]] <= 1'b1;
      if (bus.mem_addr !== wrBase + 25'(wrCount - wrStart)) wrAddrErrs <= wrAddrErrs + 1;
      wrCount <= wrCount + 1;
    end
  end

  // sclk low for 4 clk, high for 2 clk; host samples miso just before each rise.
  task automatic spiByte(input logic [7:0] txb, output logic [7:0] rxb);
    for (int i = 7; i >= 0; i--) begin
      bus.mosi = txb[i];
      repeat (4) @(negedge clk);
      rxb[i] = bus.miso;
      bus.sclk = 1'b1;
      repeat (2) @(negedge clk);
      bus.sclk = 1'b0;
    end
  endtask

  task automatic sendCmd(input logic [5:0] idx, input logic [31:0] arg);
    logic [7:0] d;
    spiByte({2'b01, idx}, d);
    spiByte(arg[31:24], d);
    spiByte(arg[23:16], d);
    spiByte(arg[15:8], d);
    spiByte(arg[7:0], d);
    spiByte(8'h95, d);
  endtask

  task automatic readResp(input int n, output logic [47:0] r);
    logic [7:0] b;
    r = 48'h0;
    for (int i = 0; i < n; i++) begin
      spiByte(8'hFF, b);
      r = {r[39:0], b};
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    bus.cs = 1'b1;
    bus.sclk = 1'b0;
    bus.mosi = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (bus.miso !== 1'b1) begin errors++; $display("[TB] FAIL reset_miso got=%b want=1", bus.miso); end
    checks++; if (bus.mem_wr !== 1'b0) begin errors++; $display("[TB] FAIL reset_mem_wr got=%b want=0", bus.mem_wr); end
    checks++; if (bus.mem_addr !== 25'h0) begin errors++; $display("[TB] FAIL reset_mem_addr got=%h want=0", bus.mem_addr); end
    checks++; if (bus.mem_wdata !== 8'h0) begin errors++; $display("[TB] FAIL reset_mem_wdata got=%h want=0", bus.mem_wdata); end
    checks++; if (idle_state !== 1'b1) begin errors++; $display("[TB] FAIL reset_idle got=%b want=1", idle_state); end
    checks++; if (active !== 1'b0) begin errors++; $display("[TB] FAIL reset_active got=%b want=0", active); end
    bus.cs = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_pre_init;
    logic [47:0] r;
    sendCmd(6'd17, 32'h600);
    readResp(6, r);
    checks++; if (r !== 48'hFF05_FFFF_FFFF) begin errors++; $display("[TB] FAIL preinit_cmd17 got=%h want=ff05ffffffff", r); end
    checks++; if (active !== 1'b0) begin errors++; $display("[TB] FAIL preinit_active got=%b want=0", active); end
    sendCmd(6'd5, 32'h0);
    readResp(2, r);
    checks++; if (r !== 48'hFF05) begin errors++; $display("[TB] FAIL preinit_cmd5 got=%h want=ff05", r); end
    checks++; if (idle_state !== 1'b1) begin errors++; $display("[TB] FAIL preinit_idle got=%b want=1", idle_state); end
  endtask

  task automatic test_init;
    logic [47:0] r;
    sendCmd(6'd0, 32'h0);
    readResp(2, r);
    checks++; if (r !== 48'hFF01) begin errors++; $display("[TB] FAIL init_cmd0 got=%h want=ff01", r); end
    sendCmd(6'd8, 32'h1AA);
    readResp(6, r);
    checks++; if (r !== 48'hFF01_0000_01AA) begin errors++; $display("[TB] FAIL init_cmd8 got=%h want=ff01000001aa", r); end
    sendCmd(6'd55, 32'h0);
    readResp(2, r);
    checks++; if (r !== 48'hFF01) begin errors++; $display("[TB] FAIL init_cmd55 got=%h want=ff01", r); end
    sendCmd(6'd41, 32'h4000_0000);
    readResp(2, r);
    checks++; if (r !== 48'hFF00) begin errors++; $display("[TB] FAIL init_acmd41 got=%h want=ff00", r); end
    checks++; if (idle_state !== 1'b0) begin errors++; $display("[TB] FAIL init_idle got=%b want=0", idle_state); end
    sendCmd(6'd58, 32'h0);
    readResp(6, r);
    checks++; if (r !== 48'hFF00_00FF_8000) begin errors++; $display("[TB] FAIL init_cmd58 got=%h want=ff0000ff8000", r); end
  endtask

  task automatic test_read;
    logic [47:0] r;
    logic [7:0]  b;
    int          bad = 0;
    sendCmd(6'd17, 32'h600);
    readResp(4, r);
    checks++; if (r !== 48'hFF00_FFFE) begin errors++; $display("[TB] FAIL read_header got=%h want=ff00fffe", r); end
    for (int i = 0; i < 512; i++) begin
      spiByte(8'hFF, b);
      if (b !== 8'(i)) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("[TB] FAIL read_data wrong_bytes=%0d want=0", bad); end
    readResp(2, r);
    checks++; if (r !== 48'hFFFF) begin errors++; $display("[TB] FAIL read_crc got=%h want=ffff", r); end
    checks++; if (active !== 1'b0) begin errors++; $display("[TB] FAIL read_active got=%b want=0", active); end
  endtask

  task automatic test_write;
    logic [47:0] r;
    logic [7:0]  b;
    int          bad = 0;
    int          errStart;
    wrBase = 25'h400;
    wrStart = wrCount;
    errStart = wrAddrErrs;
    sendCmd(6'd24, 32'h400);
    readResp(2, r);
    checks++; if (r !== 48'hFF00) begin errors++; $display("[TB] FAIL write_r1 got=%h want=ff00", r); end
    spiByte(8'hFF, b);
    spiByte(8'hFE, b);
    for (int i = 0; i < 512; i++) spiByte(8'hA5 ^ 8'(i), b);
    spiByte(8'h12, b);
    spiByte(8'h34, b);
    readResp(6, r);
    checks++; if (r !== 48'h0500_0000_00FF) begin errors++; $display("[TB] FAIL write_resp got=%h want=0500000000ff", r); end
    checks++; if (wrCount - wrStart != 512) begin errors++; $display("[TB] FAIL write_pulses got=%0d want=512", wrCount - wrStart); end
    checks++; if (wrAddrErrs != errStart) begin errors++; $display("[TB] FAIL write_addr bad_addrs=%0d want=0", wrAddrErrs - errStart); end
    for (int i = 0; i < 512; i++) begin
      if (!written[12'h400 + 12'(i)] || mem[12'h400 + 12'(i)] !== (8'hA5 ^ 8'(i))) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("[TB] FAIL write_data wrong_bytes=%0d want=0", bad); end
  endtask

  task automatic test_range;
    logic [47:0] r;
    sendCmd(6'd17, 32'h0200_0000);
    readResp(2, r);
    checks++; if (r !== 48'hFF20) begin errors++; $display("[TB] FAIL range_r1 got=%h want=ff20", r); end
    sendCmd(6'd16, 32'h200);
    readResp(2, r);
    checks++; if (r !== 48'hFF00) begin errors++; $display("[TB] FAIL range_next got=%h want=ff00", r); end
  endtask

  task automatic test_abort;
    logic [47:0] r;
    logic [7:0]  b;
    logic [7:0]  want;
    int          bad = 0;
    int          errStart;
    wrBase = 25'h400;
    wrStart = wrCount;
    errStart = wrAddrErrs;
    sendCmd(6'd24, 32'h400);
    readResp(2, r);
    spiByte(8'hFF, b);
    spiByte(8'hFE, b);
    for (int i = 0; i < 100; i++) spiByte(8'h3C ^ 8'(i), b);
    repeat (4) @(negedge clk);
    bus.cs = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (active !== 1'b0) begin errors++; $display("[TB] FAIL abort_active got=%b want=0", active); end
    checks++; if (bus.miso !== 1'b1) begin errors++; $display("[TB] FAIL abort_miso got=%b want=1", bus.miso); end
    repeat (6) @(negedge clk);
    checks++; if (wrCount - wrStart != 100) begin errors++; $display("[TB] FAIL abort_pulses got=%0d want=100", wrCount - wrStart); end
    checks++; if (wrAddrErrs != errStart) begin errors++; $display("[TB] FAIL abort_addr bad_addrs=%0d want=0", wrAddrErrs - errStart); end
    bus.cs = 1'b0;
    repeat (4) @(negedge clk);
    sendCmd(6'd17, 32'h400);
    readResp(4, r);
    checks++; if (r !== 48'hFF00_FFFE) begin errors++; $display("[TB] FAIL abort_read_header got=%h want=ff00fffe", r); end
    for (int i = 0; i < 102; i++) begin
      spiByte(8'hFF, b);
      want = (i < 100) ? (8'h3C ^ 8'(i)) : (8'hA5 ^ 8'(i));
      if (b !== want) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("[TB] FAIL abort_read_data wrong_bytes=%0d want=0", bad); end
    bus.cs = 1'b1;
    repeat (4) @(negedge clk);
    bus.cs = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset_mid;
    logic [47:0] r;
    logic [7:0]  b;
    logic [7:0]  d;
    int          n;
    wrBase = 25'h800;
    wrStart = wrCount;
    sendCmd(6'd24, 32'h800);
    readResp(2, r);
    checks++; if (r !== 48'hFF00) begin errors++; $display("[TB] FAIL rstmid_r1 got=%h want=ff00", r); end
    spiByte(8'hFF, b);
    spiByte(8'hFE, b);
    for (int i = 0; i < 9; i++) spiByte(8'h50 + 8'(i), b);
    d = 8'h77;
    for (int i = 7; i >= 0; i--) begin
      bus.mosi = d[i];
      repeat (4) @(negedge clk);
      bus.sclk = 1'b1;
      if (i != 0) begin
        repeat (2) @(negedge clk);
        bus.sclk = 1'b0;
      end
    end
    n = 0;
    while (bus.mem_wr !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    checks++; if (bus.mem_wr !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_wait mem_wr got=%b want=1 within 10 clk", bus.mem_wr); end
    reset = 1'b1;
    #1;
    checks++; if (bus.mem_wr !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_mem_wr got=%b want=0", bus.mem_wr); end
    checks++; if (active !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_active got=%b want=0", active); end
    checks++; if (idle_state !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_idle got=%b want=1", idle_state); end
    checks++; if (bus.miso !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_miso got=%b want=1", bus.miso); end
    checks++; if (bus.mem_addr !== 25'h0) begin errors++; $display("[TB] FAIL rstmid_mem_addr got=%h want=0", bus.mem_addr); end
    bus.sclk = 1'b0;
    bus.cs = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (wrCount - wrStart != 9) begin errors++; $display("[TB] FAIL rstmid_pulses got=%0d want=9", wrCount - wrStart); end
    reset = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    $display("[TB] sd_spi_responder bench start");
    test_reset();
    test_pre_init();
    test_init();
    test_read();
    test_write();
    test_range();
    test_abort();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
